fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Core-side initiator for the private FPU. Accepts one floating-point request at a time from the integer pipeline over a valid/ready handshake. Drives operands, rounding mode, operator and enable to the FPU and holds them stable until the FPU signals a valid result. Captures the result and returns it with its tag to writeback over a second valid/ready handshake, with a cycle-count timeout that guarantees a response.

## Interface
- C_OP, fpu_defs::C_OP — operand/result width
- C_RM, fpu_defs::C_RM — rounding-mode width
- C_CMD, fpu_defs::C_CMD — operator width
- C_TAG, 5 — request tag width (destination register index)
- C_TIMEOUT, fpu_defs::C_FPU_TIMEOUT (16) — max cycles waiting for FPU valid; must be ≥2
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when both high
- req_operand_a_i / req_operand_b_i  in  C_OP  operands
- req_rm_i  in  C_RM  rounding mode
- req_cmd_i  in  C_CMD  FPU operator
- req_tag_i  in  C_TAG  tag returned with result
- fpu_operand_a_o / fpu_operand_b_o  out  C_OP  to FPU
- fpu_rm_o  out  C_RM;  fpu_operator_o  out  C_CMD
- fpu_enable_o  out  1  FPU enable, held until result
- fpu_ready_i  in  1  FPU ready
- fpu_result_i  in  C_OP;  fpu_valid_i  in  1  FPU result valid
- resp_valid_o  out  1;  resp_ready_i  in  1
- resp_result_o  out  C_OP;  resp_tag_o  out  C_TAG
- resp_err_o  out  1  response caused by timeout

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: req_ready_o = fpu_ready_i. On request handshake, register operands/rm/cmd/tag, clear the timeout counter, and go to ISSUE.
- ISSUE: fpu_enable_o = 1, FPU outputs constant. req_ready_o = 0.
  - The counter increments each cycle.
  - fpu_valid_i = 1: capture fpu_result_i, set resp_err = 0, go to RESP.
  - Else, if counter == C_TIMEOUT-1: set result = 0, resp_err = 1, go to RESP.
  - If valid arrives in the timeout cycle, valid wins (err = 0).
- RESP: resp_valid_o = 1; result, tag and err are held stable until handshake. fpu_enable_o = 0.
  - req_ready_o = resp_ready_i && fpu_ready_i.
  - Response handshake with no new request: go to IDLE.
  - Response handshake and request handshake in the same cycle: load the new request and go directly to ISSUE (back-to-back).
- fpu_valid_i outside ISSUE is ignored.
- Counter width is $clog2(C_TIMEOUT). It saturates and never wraps.

## Timing
- All outputs are registered except req_ready_o, which is combinational from state, resp_ready_i and fpu_ready_i.
- Request accepted at edge N: fpu_enable_o and operands valid from N+1.
- fpu_valid_i sampled high at edge M: resp_valid_o = 1 and fpu_enable_o = 0 from M+1.
- With a one-cycle FPU (valid the cycle after enable), request-to-response latency is 2 cycles. Back-to-back sustained throughput is one op per 2 cycles.
- Timeout: with no valid, resp_valid_o rises C_TIMEOUT+1 cycles after the request handshake edge.
- Reset values: state IDLE, counter 0, and all registered outputs 0 (fpu_enable_o, resp_valid_o, resp_err_o, result, tag, FPU operand/rm/operator outputs). req_ready_o = fpu_ready_i after reset.
- Reset mid-ISSUE or mid-RESP: the pending operation is discarded. fpu_enable_o and resp_valid_o are low from the cycle after rst is sampled high; no response is produced.

## Structure
- fpu_defs gains:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} fpu_issue_state_t
  - constant C_FPU_TIMEOUT = 16
- C_OP, C_RM and C_CMD are already defined in fpu_defs.
- The block is a single module with no sub-module. The counter and FSM are small enough to be inline.

## Test plan
- Single op: FADD with a=0x3F800000, b=0x40000000, responder latency 1 returning 0x40400000, tag 5 → resp_valid_o two cycles after the handshake, result 0x40400000, tag 5, err 0; fpu_enable_o high exactly 1 cycle.
- Slow FPU, latency 7: operands and enable stable for 7 cycles, req_ready_o low throughout, resp after valid+1.
- Timeout, C_TIMEOUT=16, no fpu_valid_i → resp at request+17 with result 0 and err 1. A late fpu_valid_i afterwards is ignored.
- Writeback backpressure: resp_ready_i low for 4 cycles → response fields held constant, no new request accepted. Then resp_ready_i=1 with req_valid_i=1 and tag 9 → same-cycle handshake on both, fpu_enable_o high next cycle with the new operands.
- Valid in the timeout cycle: fpu_valid_i arrives on the C_TIMEOUT-th ISSUE cycle → err 0, FPU result returned.
- Reset in ISSUE and in RESP: rst pulsed 1 cycle → all outputs 0 next cycle, no response emitted, next request completes normally.

Source files
------------

// File: rtl/fpu_defs.sv
// Shared FPU definitions: datapath widths, issue-controller timeout and FSM states.
package fpu_defs;

   localparam int C_OP          = 32;
   localparam int C_RM          = 3;
   localparam int C_CMD         = 4;
   localparam int C_FPU_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } fpu_issue_state_t;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Core-side initiator for the private FPU: takes one request at a time, holds
// the command on the FPU until it answers (or a timeout expires), then returns
// the result with its tag to writeback.
module fpu_issue_ctrl #(
   parameter int C_OP      = fpu_defs::C_OP,
   parameter int C_RM      = fpu_defs::C_RM,
   parameter int C_CMD     = fpu_defs::C_CMD,
   parameter int C_TAG     = 5,
   parameter int C_TIMEOUT = fpu_defs::C_FPU_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [C_OP-1:0]  req_operand_a_i,
   input  logic [C_OP-1:0]  req_operand_b_i,
   input  logic [C_RM-1:0]  req_rm_i,
   input  logic [C_CMD-1:0] req_cmd_i,
   input  logic [C_TAG-1:0] req_tag_i,

   output logic [C_OP-1:0]  fpu_operand_a_o,
   output logic [C_OP-1:0]  fpu_operand_b_o,
   output logic [C_RM-1:0]  fpu_rm_o,
   output logic [C_CMD-1:0] fpu_operator_o,
   output logic             fpu_enable_o,
   input  logic             fpu_ready_i,
   input  logic [C_OP-1:0]  fpu_result_i,
   input  logic             fpu_valid_i,

   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [C_OP-1:0]  resp_result_o,
   output logic [C_TAG-1:0] resp_tag_o,
   output logic             resp_err_o
);

   localparam int CW = $clog2(C_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT - 1);

   fpu_defs::fpu_issue_state_t state_q;
   fpu_defs::fpu_issue_state_t state_d;

   logic [CW-1:0] cnt_q;
   logic          accept;
   logic          timeout_hit;

   assign accept      = req_valid_i && req_ready_o;
   assign timeout_hit = (cnt_q == CNT_LAST);

   // State register; reset abandons whatever operation is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= fpu_defs::IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a valid FPU result beats a timeout landing in the same cycle,
   // and a response handshake may chain straight into the next request.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         fpu_defs::IDLE: begin
            if (accept) begin
               state_d = fpu_defs::ISSUE;
            end
         end
         fpu_defs::ISSUE: begin
            if (fpu_valid_i || timeout_hit) begin
               state_d = fpu_defs::RESP;
            end
         end
         fpu_defs::RESP: begin
            if (resp_ready_i) begin
               state_d = accept ? fpu_defs::ISSUE : fpu_defs::IDLE;
            end
         end
         default: state_d = fpu_defs::IDLE;
      endcase
   end

   // Request ready: only when the FPU can take work and no result is stuck.
   always_comb begin
      req_ready_o = 1'b0;
      unique case (state_q)
         fpu_defs::IDLE:  req_ready_o = fpu_ready_i;
         fpu_defs::ISSUE: req_ready_o = 1'b0;
         fpu_defs::RESP:  req_ready_o = resp_ready_i && fpu_ready_i;
         default:         req_ready_o = 1'b0;
      endcase
   end

   // Registered FPU command, response fields and the saturating wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q           <= '0;
         fpu_operand_a_o <= '0;
         fpu_operand_b_o <= '0;
         fpu_rm_o        <= '0;
         fpu_operator_o  <= '0;
         fpu_enable_o    <= 1'b0;
         resp_valid_o    <= 1'b0;
         resp_result_o   <= '0;
         resp_tag_o      <= '0;
         resp_err_o      <= 1'b0;
      end else begin
         unique case (state_q)
            fpu_defs::ISSUE: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + CW'(1);
               end
               if (fpu_valid_i) begin
                  resp_result_o <= fpu_result_i;
                  resp_err_o    <= 1'b0;
                  resp_valid_o  <= 1'b1;
                  fpu_enable_o  <= 1'b0;
               end else if (timeout_hit) begin
                  resp_result_o <= '0;
                  resp_err_o    <= 1'b1;
                  resp_valid_o  <= 1'b1;
                  fpu_enable_o  <= 1'b0;
               end
            end
            fpu_defs::RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
               end
            end
            default: begin
            end
         endcase

         if (accept) begin
            cnt_q           <= '0;
            fpu_operand_a_o <= req_operand_a_i;
            fpu_operand_b_o <= req_operand_b_i;
            fpu_rm_o        <= req_rm_i;
            fpu_operator_o  <= req_cmd_i;
            fpu_enable_o    <= 1'b1;
            resp_tag_o      <= req_tag_i;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a hand-driven FPU responder.
module tb_fpu_issue_ctrl;

   localparam int OPW  = fpu_defs::C_OP;
   localparam int RMW  = fpu_defs::C_RM;
   localparam int CMDW = fpu_defs::C_CMD;
   localparam int TAGW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid_i;
   logic            req_ready_o;
   logic [OPW-1:0]  req_operand_a_i;
   logic [OPW-1:0]  req_operand_b_i;
   logic [RMW-1:0]  req_rm_i;
   logic [CMDW-1:0] req_cmd_i;
   logic [TAGW-1:0] req_tag_i;
   logic [OPW-1:0]  fpu_operand_a_o;
   logic [OPW-1:0]  fpu_operand_b_o;
   logic [RMW-1:0]  fpu_rm_o;
   logic [CMDW-1:0] fpu_operator_o;
   logic            fpu_enable_o;
   logic            fpu_ready_i;
   logic [OPW-1:0]  fpu_result_i;
   logic            fpu_valid_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [OPW-1:0]  resp_result_o;
   logic [TAGW-1:0] resp_tag_o;
   logic            resp_err_o;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(
      .C_OP      (OPW),
      .C_RM      (RMW),
      .C_CMD     (CMDW),
      .C_TAG     (TAGW),
      .C_TIMEOUT (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_operand_a_i (req_operand_a_i),
      .req_operand_b_i (req_operand_b_i),
      .req_rm_i        (req_rm_i),
      .req_cmd_i       (req_cmd_i),
      .req_tag_i       (req_tag_i),
      .fpu_operand_a_o (fpu_operand_a_o),
      .fpu_operand_b_o (fpu_operand_b_o),
      .fpu_rm_o        (fpu_rm_o),
      .fpu_operator_o  (fpu_operator_o),
      .fpu_enable_o    (fpu_enable_o),
      .fpu_ready_i     (fpu_ready_i),
      .fpu_result_i    (fpu_result_i),
      .fpu_valid_i     (fpu_valid_i),
      .resp_valid_o    (resp_valid_o),
      .resp_ready_i    (resp_ready_i),
      .resp_result_o   (resp_result_o),
      .resp_tag_o      (resp_tag_o),
      .resp_err_o      (resp_err_o)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, ending on the next falling edge.
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a request and return at the falling edge after its handshake edge.
   task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                input logic [RMW-1:0] rm, input logic [CMDW-1:0] cmd,
                                input logic [TAGW-1:0] tag);
      logic ok;
      ok = 1'b0;
      req_operand_a_i = a;
      req_operand_b_i = b;
      req_rm_i        = rm;
      req_cmd_i       = cmd;
      req_tag_i       = tag;
      req_valid_i     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         ok = req_ready_o;
         @(posedge clk);
         @(negedge clk);
         if (ok) break;
      end
      req_valid_i = 1'b0;
      checkOutput("req_handshake", ok, 1'b1);
   endtask

   // FPU answers on the latency-th ISSUE cycle; checks the hold period and the response.
   task automatic runFpu(input int latency, input logic [OPW-1:0] res, input logic [OPW-1:0] expA);
      for (int k = 1; k <= latency; k++) begin
         checkOutput("issue_enable", fpu_enable_o, 1'b1);
         checkOutput("issue_opa_stable", fpu_operand_a_o, expA);
         checkOutput("issue_req_ready_low", req_ready_o, 1'b0);
         checkOutput("issue_no_resp", resp_valid_o, 1'b0);
         if (k == latency) begin
            fpu_valid_i  = 1'b1;
            fpu_result_i = res;
         end
         stepCycle();
      end
      fpu_valid_i = 1'b0;
      checkOutput("resp_valid", resp_valid_o, 1'b1);
      checkOutput("resp_enable_low", fpu_enable_o, 1'b0);
      checkOutput("resp_result", resp_result_o, res);
      checkOutput("resp_err", resp_err_o, 1'b0);
   endtask

   // Accept the pending response and check it is retired.
   task automatic consumeResp();
      resp_ready_i = 1'b1;
      stepCycle();
      resp_ready_i = 1'b0;
      checkOutput("resp_retired", resp_valid_o, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst             = 1'b1;
      req_valid_i     = 1'b0;
      req_operand_a_i = '0;
      req_operand_b_i = '0;
      req_rm_i        = '0;
      req_cmd_i       = '0;
      req_tag_i       = '0;
      fpu_ready_i     = 1'b1;
      fpu_result_i    = '0;
      fpu_valid_i     = 1'b0;
      resp_ready_i    = 1'b0;

      // Reset state
      @(negedge clk);
      stepCycle();
      stepCycle();
      rst = 1'b0;
      #1;
      checkOutput("rst_enable", fpu_enable_o, 1'b0);
      checkOutput("rst_resp_valid", resp_valid_o, 1'b0);
      checkOutput("rst_err", resp_err_o, 1'b0);
      checkOutput("rst_result", resp_result_o, 32'h0);
      checkOutput("rst_tag", resp_tag_o, 5'd0);
      checkOutput("rst_opa", fpu_operand_a_o, 32'h0);
      checkOutput("rst_operator", fpu_operator_o, 4'h0);
      checkOutput("rst_req_ready", req_ready_o, 1'b1);
      fpu_ready_i = 1'b0;
      #1;
      checkOutput("idle_req_ready_fpu_busy", req_ready_o, 1'b0);
      fpu_ready_i = 1'b1;
      @(negedge clk);

      // Single FADD, one-cycle FPU
      applyStimulus(32'h3F800000, 32'h40000000, 3'd0, 4'd0, 5'd5);
      checkOutput("fadd_opb", fpu_operand_b_o, 32'h40000000);
      checkOutput("fadd_operator", fpu_operator_o, 4'd0);
      runFpu(1, 32'h40400000, 32'h3F800000);
      checkOutput("fadd_tag", resp_tag_o, 5'd5);
      consumeResp();
      #1;
      checkOutput("fadd_back_idle_ready", req_ready_o, 1'b1);
      @(negedge clk);

      // Slow FPU, latency 7
      applyStimulus(32'h00000001, 32'h00000002, 3'd2, 4'd1, 5'd3);
      checkOutput("slow_rm", fpu_rm_o, 3'd2);
      runFpu(7, 32'h00001234, 32'h00000001);
      checkOutput("slow_tag", resp_tag_o, 5'd3);

      // Writeback backpressure, then same-cycle response and request handshakes
      req_operand_a_i = 32'h0000000A;
      req_operand_b_i = 32'h0000000B;
      req_rm_i        = 3'd1;
      req_cmd_i       = 4'd2;
      req_tag_i       = 5'd9;
      req_valid_i     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("bp_req_ready_low", req_ready_o, 1'b0);
         checkOutput("bp_resp_valid_held", resp_valid_o, 1'b1);
         checkOutput("bp_result_held", resp_result_o, 32'h00001234);
         checkOutput("bp_tag_held", resp_tag_o, 5'd3);
         checkOutput("bp_enable_low", fpu_enable_o, 1'b0);
         stepCycle();
      end
      resp_ready_i = 1'b1;
      #1;
      checkOutput("b2b_req_ready", req_ready_o, 1'b1);
      stepCycle();
      resp_ready_i = 1'b0;
      req_valid_i  = 1'b0;
      checkOutput("b2b_resp_retired", resp_valid_o, 1'b0);
      checkOutput("b2b_enable", fpu_enable_o, 1'b1);
      checkOutput("b2b_opb", fpu_operand_b_o, 32'h0000000B);
      checkOutput("b2b_tag", resp_tag_o, 5'd9);
      runFpu(1, 32'h0000BEEF, 32'h0000000A);
      checkOutput("b2b_resp_tag", resp_tag_o, 5'd9);
      consumeResp();

      // Timeout with no FPU answer, then a late valid that must be ignored
      applyStimulus(32'h00000077, 32'h00000078, 3'd0, 4'd3, 5'd7);
      for (int k = 1; k <= 16; k++) begin
         checkOutput("to_waiting", resp_valid_o, 1'b0);
         stepCycle();
      end
      checkOutput("to_resp_valid", resp_valid_o, 1'b1);
      checkOutput("to_err", resp_err_o, 1'b1);
      checkOutput("to_result_zero", resp_result_o, 32'h0);
      checkOutput("to_tag", resp_tag_o, 5'd7);
      checkOutput("to_enable_low", fpu_enable_o, 1'b0);
      fpu_valid_i  = 1'b1;
      fpu_result_i = 32'h0000DEAD;
      stepCycle();
      stepCycle();
      fpu_valid_i = 1'b0;
      checkOutput("late_valid_result", resp_result_o, 32'h0);
      checkOutput("late_valid_err", resp_err_o, 1'b1);
      consumeResp();

      // Valid arriving in the timeout cycle wins
      applyStimulus(32'h00000055, 32'h00000056, 3'd0, 4'd0, 5'd11);
      runFpu(16, 32'h00005555, 32'h00000055);
      consumeResp();

      // Reset during ISSUE
      applyStimulus(32'h00000033, 32'h00000034, 3'd4, 4'd5, 5'd12);
      checkOutput("rsti_enable_before", fpu_enable_o, 1'b1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rsti_enable", fpu_enable_o, 1'b0);
      checkOutput("rsti_resp_valid", resp_valid_o, 1'b0);
      checkOutput("rsti_opa", fpu_operand_a_o, 32'h0);
      checkOutput("rsti_tag", resp_tag_o, 5'd0);
      checkOutput("rsti_rm", fpu_rm_o, 3'd0);
      fpu_valid_i  = 1'b1;
      fpu_result_i = 32'h00000099;
      for (int k = 0; k < 2; k++) begin
         stepCycle();
         checkOutput("rsti_no_resp", resp_valid_o, 1'b0);
      end
      fpu_valid_i = 1'b0;
      applyStimulus(32'h00000044, 32'h00000045, 3'd0, 4'd0, 5'd13);
      runFpu(2, 32'h00004444, 32'h00000044);
      checkOutput("rsti_next_tag", resp_tag_o, 5'd13);
      consumeResp();

      // Reset during RESP
      applyStimulus(32'h00000061, 32'h00000062, 3'd0, 4'd0, 5'd14);
      runFpu(2, 32'h00004242, 32'h00000061);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rstr_resp_valid", resp_valid_o, 1'b0);
      checkOutput("rstr_result", resp_result_o, 32'h0);
      checkOutput("rstr_tag", resp_tag_o, 5'd0);
      stepCycle();
      checkOutput("rstr_no_resp", resp_valid_o, 1'b0);
      applyStimulus(32'h00000071, 32'h00000072, 3'd0, 4'd0, 5'd15);
      runFpu(3, 32'h00007171, 32'h00000071);
      checkOutput("rstr_next_tag", resp_tag_o, 5'd15);
      consumeResp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
